// File: rtl/sfr_read_unit_pkg.sv
// Shared definitions for the SFR read unit: SFR byte addresses, FSM state
// encoding, source-select codes, the decoded-read bundle and small address
// helpers used by both the read mux and the lock-release compare.
package sfr_read_unit_pkg;

  localparam logic [7:0] SFR_ADDR_ACC = 8'hE0;
  localparam logic [7:0] SFR_ADDR_B   = 8'hF0;
  localparam logic [7:0] SFR_ADDR_PSW = 8'hD0;
  localparam logic [7:0] SFR_ADDR_SP  = 8'h81;
  localparam logic [7:0] SFR_ADDR_DPL = 8'h82;
  localparam logic [7:0] SFR_ADDR_DPH = 8'h83;

  localparam int LOCK_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RESP = 2'b01,
    ST_LOCK = 2'b10
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_ACC  = 3'd1,
    SEL_B    = 3'd2,
    SEL_PSW  = 3'd3,
    SEL_SP   = 3'd4,
    SEL_DPL  = 3'd5,
    SEL_DPH  = 3'd6
  } sfr_sel_e;

  // Result of one decode: selected byte, selected bit, hit flag and the
  // byte address a lock on this read would guard.
  typedef struct packed {
    logic [7:0] data;
    logic       bit_val;
    logic       mapped;
    logic [7:0] lock_addr;
  } rd_sel_t;

  // Byte that holds a bit address.
  function automatic logic [7:0] bit_base(input logic [7:0] a);
    return {a[7:3], 3'b000};
  endfunction

  function automatic sfr_sel_e decode_byte(input logic [7:0] a);
    sfr_sel_e s;
    s = SEL_NONE;
    case (a)
      SFR_ADDR_ACC: s = SEL_ACC;
      SFR_ADDR_B:   s = SEL_B;
      SFR_ADDR_PSW: s = SEL_PSW;
      SFR_ADDR_SP:  s = SEL_SP;
      SFR_ADDR_DPL: s = SEL_DPL;
      SFR_ADDR_DPH: s = SEL_DPH;
      default:      s = SEL_NONE;
    endcase
    return s;
  endfunction

  // Only ACC, B and PSW are bit-addressable.
  function automatic sfr_sel_e decode_bit(input logic [7:0] a);
    sfr_sel_e s;
    s = SEL_NONE;
    case (bit_base(a))
      SFR_ADDR_ACC: s = SEL_ACC;
      SFR_ADDR_B:   s = SEL_B;
      SFR_ADDR_PSW: s = SEL_PSW;
      default:      s = SEL_NONE;
    endcase
    return s;
  endfunction

  // A bit lock is released by any write landing in the locked byte;
  // a byte lock needs the exact address.
  function automatic logic lock_match(input logic [7:0] wr_addr,
                                      input logic [7:0] lock_addr,
                                      input logic       lock_is_bit);
    logic [7:0] cmp_addr;
    cmp_addr = lock_is_bit ? bit_base(wr_addr) : wr_addr;
    return (cmp_addr == lock_addr);
  endfunction

endpackage

// File: rtl/sfr_rd_mux.sv
// Combinational SFR read mux: decodes a byte or bit address, selects the
// live SFR byte and extracts the addressed bit.
// Build option: SFR_RD_PARITY_EN replaces PSW bit 0 with the even parity
// of ACC on every PSW read; undefined returns PSW as-is.
module sfr_rd_mux
  import sfr_read_unit_pkg::*;
#(
  parameter logic [7:0] UNMAPPED_VAL = 8'h00
) (
  input  logic       rd_bit_en,
  input  logic [7:0] addr,
  input  logic [7:0] acc_data,
  input  logic [7:0] b_data,
  input  logic [7:0] psw_data,
  input  logic [7:0] sp_data,
  input  logic [7:0] dpl_data,
  input  logic [7:0] dph_data,
  output rd_sel_t    sel
);

  logic [7:0] psw_eff;
  sfr_sel_e   sel_id;
  logic [7:0] base_addr;
  logic [7:0] sel_byte;
  logic       hit;

  // PSW as seen by readers, optionally carrying live ACC parity in bit 0.
`ifdef SFR_RD_PARITY_EN
  always_comb psw_eff = {psw_data[7:1], ^acc_data};
`else
  always_comb psw_eff = psw_data;
`endif

  // Address decode: bit reads are mapped onto their containing byte.
  always_comb begin
    base_addr = rd_bit_en ? bit_base(addr) : addr;
    sel_id    = rd_bit_en ? decode_bit(addr) : decode_byte(addr);
    hit       = (sel_id != SEL_NONE);
  end

  // Source byte select, unmapped addresses return the configured filler.
  always_comb begin
    sel_byte = UNMAPPED_VAL;
    case (sel_id)
      SEL_ACC: sel_byte = acc_data;
      SEL_B:   sel_byte = b_data;
      SEL_PSW: sel_byte = psw_eff;
      SEL_SP:  sel_byte = sp_data;
      SEL_DPL: sel_byte = dpl_data;
      SEL_DPH: sel_byte = dph_data;
      default: sel_byte = UNMAPPED_VAL;
    endcase
  end

  // Pack the result; the bit output is only meaningful for mapped bit reads.
  always_comb begin
    sel           = '0;
    sel.data      = sel_byte;
    sel.bit_val   = hit & rd_bit_en & sel_byte[addr[2:0]];
    sel.mapped    = hit;
    sel.lock_addr = base_addr;
  end

endmodule

// File: rtl/sfr_read_unit.sv
// SFR read unit: latency-1 byte/bit reads of the core SFRs with an optional
// read-modify-write lock that holds the result until the core writes the
// locked byte or the lock timer expires.
// Build option: SFR_RD_PARITY_EN (PSW bit 0 carries ACC parity on reads).
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no read in flight, outputs quiet
//   ST_RESP | result presented for one cycle (rd_valid), may re-capture
//   ST_LOCK | RMW lock held: busy high, result frozen, reads ignored
module sfr_read_unit
  import sfr_read_unit_pkg::*;
#(
  parameter logic [7:0] UNMAPPED_VAL = 8'h00,
  parameter int         LOCK_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rd_en,
  input  logic       rd_bit_en,
  input  logic       rmw,
  input  logic [7:0] addr,
  input  logic [7:0] acc_data,
  input  logic [7:0] b_data,
  input  logic [7:0] psw_data,
  input  logic [7:0] sp_data,
  input  logic [7:0] dpl_data,
  input  logic [7:0] dph_data,
  input  logic       write_en,
  input  logic [7:0] wr_addr,
  output logic [7:0] rd_data,
  output logic       rd_bit,
  output logic       rd_valid,
  output logic       rd_err,
  output logic       busy
);

  // Timer counts down from TIMEOUT-1 so the lock lasts exactly TIMEOUT cycles.
  localparam logic [LOCK_CNT_W-1:0] LOCK_LOAD = LOCK_CNT_W'(LOCK_TIMEOUT - 1);

  rd_state_e             state;
  rd_sel_t               mux_sel;
  logic [LOCK_CNT_W-1:0] lock_cnt;
  logic [7:0]            lock_addr;
  logic                  lock_is_bit;
  logic                  lock_pend;
  logic                  capture;
  logic                  wr_hit;

  sfr_rd_mux #(
    .UNMAPPED_VAL (UNMAPPED_VAL)
  ) u_mux (
    .rd_bit_en (rd_bit_en),
    .addr      (addr),
    .acc_data  (acc_data),
    .b_data    (b_data),
    .psw_data  (psw_data),
    .sp_data   (sp_data),
    .dpl_data  (dpl_data),
    .dph_data  (dph_data),
    .sel       (mux_sel)
  );

  // A read is taken in IDLE, or in RESP when no lock is pending.
  always_comb begin
    capture = rd_en && ((state == ST_IDLE) || ((state == ST_RESP) && !lock_pend));
    wr_hit  = write_en && lock_match(wr_addr, lock_addr, lock_is_bit);
  end

  // Result and lock-address capture; held untouched while locked.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data     <= 8'h00;
      rd_bit      <= 1'b0;
      lock_addr   <= 8'h00;
      lock_is_bit <= 1'b0;
    end else if (capture) begin
      rd_data     <= mux_sel.data;
      rd_bit      <= mux_sel.bit_val;
      lock_addr   <= mux_sel.lock_addr;
      lock_is_bit <= rd_bit_en;
    end
  end

  // Sequencing FSM with registered strobes, busy flag and lock timer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      busy      <= 1'b0;
      lock_pend <= 1'b0;
      lock_cnt  <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (capture) begin
            state     <= ST_RESP;
            rd_valid  <= 1'b1;
            rd_err    <= ~mux_sel.mapped;
            lock_pend <= rmw & mux_sel.mapped;
          end
        end
        ST_RESP: begin
          if (lock_pend) begin
            state     <= ST_LOCK;
            busy      <= 1'b1;
            lock_pend <= 1'b0;
            lock_cnt  <= LOCK_LOAD;
          end else if (capture) begin
            state     <= ST_RESP;
            rd_valid  <= 1'b1;
            rd_err    <= ~mux_sel.mapped;
            lock_pend <= rmw & mux_sel.mapped;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (wr_hit || (lock_cnt == '0)) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          lock_pend <= 1'b0;
          lock_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfr_read_unit.sv
// Self-checking bench for sfr_read_unit: directed scenarios plus randomized
// reads compared against a table-driven SFR reference model.
module tb_sfr_read_unit;

  localparam logic [7:0] UNMAPPED = 8'h5A;
  localparam int         TMO      = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rd_en = 1'b0;
  logic       rd_bit_en = 1'b0;
  logic       rmw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] acc_data = 8'h00;
  logic [7:0] b_data = 8'h00;
  logic [7:0] psw_data = 8'h00;
  logic [7:0] sp_data = 8'h00;
  logic [7:0] dpl_data = 8'h00;
  logic [7:0] dph_data = 8'h00;
  logic       write_en = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] rd_data;
  logic       rd_bit;
  logic       rd_valid;
  logic       rd_err;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected result of the most recent read, used to check hold behaviour.
  logic [7:0] last_byte;
  logic       last_bit;

  logic [7:0] sfr_addr_tbl [6] = '{8'hE0, 8'hF0, 8'hD0, 8'h81, 8'h82, 8'h83};

  sfr_read_unit #(
    .UNMAPPED_VAL (UNMAPPED),
    .LOCK_TIMEOUT (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_bit_en (rd_bit_en),
    .rmw       (rmw),
    .addr      (addr),
    .acc_data  (acc_data),
    .b_data    (b_data),
    .psw_data  (psw_data),
    .sp_data   (sp_data),
    .dpl_data  (dpl_data),
    .dph_data  (dph_data),
    .write_en  (write_en),
    .wr_addr   (wr_addr),
    .rd_data   (rd_data),
    .rd_bit    (rd_bit),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic randomize_sfrs();
    acc_data = 8'($urandom);
    b_data   = 8'($urandom);
    psw_data = 8'($urandom);
    sp_data  = 8'($urandom);
    dpl_data = 8'($urandom);
    dph_data = 8'($urandom);
  endtask

  // Value a reader should see for table entry idx, given current SFR contents.
  function automatic logic [7:0] live_val(input int idx);
    logic [7:0] v;
    case (idx)
      0: v = acc_data;
      1: v = b_data;
`ifdef SFR_RD_PARITY_EN
      2: v = {psw_data[7:1], ^acc_data};
`else
      2: v = psw_data;
`endif
      3: v = sp_data;
      4: v = dpl_data;
      default: v = dph_data;
    endcase
    return v;
  endfunction

  // Reference: first three table entries are bit-addressable.
  task automatic model_read(input logic [7:0] a, input logic be,
                            output logic mapped, output logic [7:0] byt, output logic bt);
    logic [7:0] target;
    int lim;
    target = be ? (a & 8'hF8) : a;
    lim    = be ? 3 : 6;
    mapped = 1'b0;
    byt    = UNMAPPED;
    bt     = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (sfr_addr_tbl[i] == target) begin
        mapped = 1'b1;
        byt    = live_val(i);
        bt     = be ? byt[a % 8] : 1'b0;
      end
    end
  endtask

  // Issue one read, then check the strobe cycle against the model.
  task automatic do_read(input logic [7:0] a, input logic be, input logic r, input string tag);
    logic m;
    logic [7:0] eb;
    logic ebit;
    model_read(a, be, m, eb, ebit);
    rd_en = 1'b1; addr = a; rd_bit_en = be; rmw = r;
    tick();
    rd_en = 1'b0; rd_bit_en = 1'b0; rmw = 1'b0; write_en = 1'b0;
    randomize_sfrs();
    last_byte = eb;
    last_bit  = ebit;
    check1({tag, " valid"}, rd_valid, 1'b1);
    check1({tag, " err"}, rd_err, !m);
    if (be) check1({tag, " bit"}, rd_bit, ebit);
    else    check8({tag, " data"}, rd_data, eb);
    if (!m) begin
      check8({tag, " unmapped data"}, rd_data, UNMAPPED);
      check1({tag, " unmapped bit"}, rd_bit, 1'b0);
    end
  endtask

  function automatic logic [7:0] pick_addr();
    logic [7:0] a;
    case ($urandom_range(0, 2))
      0: a = sfr_addr_tbl[$urandom_range(0, 5)];
      1: a = sfr_addr_tbl[$urandom_range(0, 5)] | 8'($urandom_range(0, 7));
      default: a = 8'($urandom);
    endcase
    return a;
  endfunction

  initial begin
    int n;
    logic [7:0] a;
    logic be;

    // Reset state
    tick(); tick();
    check8("reset rd_data", rd_data, 8'h00);
    check1("reset rd_bit", rd_bit, 1'b0);
    check1("reset rd_valid", rd_valid, 1'b0);
    check1("reset rd_err", rd_err, 1'b0);
    check1("reset busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    // ACC byte read, one-cycle strobe
    acc_data = 8'hA5;
    do_read(8'hE0, 1'b0, 1'b0, "acc_a5");
    check8("acc_a5 const", rd_data, 8'hA5);
    tick();
    check1("acc_a5 strobe drop", rd_valid, 1'b0);
    check1("acc_a5 err drop", rd_err, 1'b0);

    // Bit reads: B.2 set, and DPL is not bit-addressable
    b_data = 8'h04;
    do_read(8'hF2, 1'b1, 1'b0, "b_bit2");
    check1("b_bit2 const", rd_bit, 1'b1);
    tick();
    do_read(8'h82, 1'b1, 1'b0, "dpl_bit");
    check1("dpl_bit err const", rd_err, 1'b1);
    tick();

    // Randomized reads, mixing back-to-back and gapped requests
    for (int i = 0; i < 60; i++) begin
      a  = pick_addr();
      be = 1'($urandom_range(0, 1));
      randomize_sfrs();
      do_read(a, be, 1'b0, "rand");
      if ($urandom_range(0, 2) == 0) begin
        tick();
        check1("rand idle valid", rd_valid, 1'b0);
        check1("rand idle busy", busy, 1'b0);
      end
    end
    tick();

    // Write to the same address as the read returns the pre-write value
    acc_data = 8'h3C; write_en = 1'b1; wr_addr = 8'hE0;
    do_read(8'hE0, 1'b0, 1'b0, "prewrite");
    check8("prewrite const", rd_data, 8'h3C);
    tick();

    // PSW parity option
    acc_data = 8'h07; psw_data = 8'h00;
    do_read(8'hD0, 1'b0, 1'b0, "psw_par");
`ifdef SFR_RD_PARITY_EN
    check8("psw_par const", rd_data, 8'h01);
`else
    check8("psw_par const", rd_data, 8'h00);
`endif
    tick();

    // RMW lock on PSW released by matching write
    do_read(8'hD0, 1'b0, 1'b1, "rmw_psw");
    check1("rmw_psw busy in resp", busy, 1'b0);
    tick();
    check1("rmw_psw busy", busy, 1'b1);
    rd_en = 1'b1; addr = 8'hE0;
    tick();
    rd_en = 1'b0;
    check1("lock ignores rd valid", rd_valid, 1'b0);
    check1("lock ignores rd busy", busy, 1'b1);
    check8("lock holds data", rd_data, last_byte);
    write_en = 1'b1; wr_addr = 8'hD0;
    tick();
    write_en = 1'b0;
    check1("rmw_psw release", busy, 1'b0);
    check1("rmw_psw release valid", rd_valid, 1'b0);
    tick();

    // RMW lock times out with only non-matching writes
    do_read(8'hF0, 1'b0, 1'b1, "rmw_tmo");
    n = 0;
    for (int k = 0; k < 40; k++) begin
      write_en = 1'($urandom_range(0, 1));
      wr_addr  = (k % 2 == 0) ? 8'hE0 : 8'h81;
      tick();
      if (!busy) break;
      n++;
      check8("tmo hold data", rd_data, last_byte);
      check1("tmo no valid", rd_valid, 1'b0);
    end
    write_en = 1'b0;
    check8("tmo lock cycles", 8'(n), 8'(TMO));
    tick();

    // Bit lock released by a write anywhere in the same byte
    do_read(8'hD3, 1'b1, 1'b1, "rmw_bit");
    tick();
    check1("rmw_bit busy", busy, 1'b1);
    check1("rmw_bit hold", rd_bit, last_bit);
    write_en = 1'b1; wr_addr = 8'hD5;
    tick();
    write_en = 1'b0;
    check1("rmw_bit release", busy, 1'b0);
    tick();

    // Unmapped RMW read never locks
    do_read(8'h10, 1'b0, 1'b1, "rmw_unmapped");
    tick();
    check1("rmw_unmapped busy", busy, 1'b0);
    tick();
    check1("rmw_unmapped busy2", busy, 1'b0);

    // Reset while locked
    do_read(8'hE0, 1'b0, 1'b1, "rst_lock");
    tick();
    check1("rst_lock busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check8("rst_lock data", rd_data, 8'h00);
    check1("rst_lock bit", rd_bit, 1'b0);
    check1("rst_lock valid", rd_valid, 1'b0);
    check1("rst_lock err", rd_err, 1'b0);
    check1("rst_lock busy clr", busy, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check1("rst_lock after valid", rd_valid, 1'b0);
      check1("rst_lock after busy", busy, 1'b0);
    end

    // Reset while presenting a result, with an RMW pending
    do_read(8'hF0, 1'b0, 1'b1, "rst_resp");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("rst_resp valid", rd_valid, 1'b0);
    check1("rst_resp busy", busy, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check1("rst_resp after valid", rd_valid, 1'b0);
      check1("rst_resp after busy", busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
